// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low segment codes, anode selects and blank codes.
// Used by both the display driver and the display decoder.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_BLANK      = 4'b1111;
    localparam logic [3:0] AN_UPPER_IDLE = 4'b1111;
    localparam logic [6:0] SEG_BLANK     = 7'h7F;

    // An[3:0] pattern that selects digit i (active low)
    localparam logic [3:0] AN_SEL [NUM_DIGITS] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Active-low segment codes, Seg[6]=a .. Seg[0]=g, indexed by hex value 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } decod_state_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_sample_t;

    localparam disp_sample_t SAMPLE_IDLE = '{an: 8'hFF, seg: SEG_BLANK, dp: 1'b1};

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } an_sel_t;

    function automatic an_sel_t anode_decode(input logic [3:0] an);
        an_sel_t r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an == AN_SEL[i]) begin
                r.hit = 1'b1;
                r.idx = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational reverse lookup of an active-low segment pattern into its hex value.
// hit is low when the pattern is not one of the 16 table entries.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       hit
);

    always_comb begin
        value = '0;
        hit   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                value = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afisare_7seg_decod.sv
// Recovers the four hex digits and decimal points from a multiplexed seven-segment bus.
// Define DECOD7_ERR_EN to pulse err on accepted samples that cannot be decoded.
module afisare_7seg_decod
    import seg7_pkg::*;
#(
    parameter int STABLE_N = 2
)
(
    input  logic       clk_out_seg,
    input  logic       reset,
    input  logic [7:0] An,
    input  logic [6:0] Seg,
    input  logic       DP,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic [3:0] DPo,
    output logic       frame_valid,
    output logic       err
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_N);

    logic [1:0]   rst_sync;
    logic         rst_n;
    disp_sample_t sample;
    disp_sample_t prev_sample;
    logic [3:0]   stable_cnt;
    logic [3:0]   cnt_cur;
    logic         same;
    logic         accept;
    an_sel_t      an_sel;
    logic [3:0]   seg_value;
    logic         seg_hit;
    logic         blank;
    logic         legal;
    logic         capture;
    logic [3:0]   cap_bits;
    logic [3:0]   mask;
    logic [3:0][3:0] shadow_val;
    logic [3:0]   shadow_dp;
    decod_state_t state;

    // Reset asserts at once but releases only on a clock edge
    always_ff @(posedge clk_out_seg or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_out_seg or negedge rst_n) begin
        if (!rst_n) begin
            sample      <= SAMPLE_IDLE;
            prev_sample <= SAMPLE_IDLE;
            stable_cnt  <= '0;
        end else begin
            sample      <= '{an: An, seg: Seg, dp: DP};
            prev_sample <= sample;
            stable_cnt  <= cnt_cur;
        end
    end

    // cnt_cur is the run length of the current registered sample; accept fires on reaching STABLE_N only
    assign same    = (sample == prev_sample);
    assign cnt_cur = !same ? 4'd1 :
                     (stable_cnt == STABLE_CNT) ? stable_cnt : 4'(stable_cnt + 4'd1);
    assign accept  = (cnt_cur == STABLE_CNT) && !(same && (stable_cnt == STABLE_CNT));

    seg7_lookup u_lookup (
        .seg   (sample.seg),
        .value (seg_value),
        .hit   (seg_hit)
    );

    assign an_sel   = anode_decode(sample.an[3:0]);
    assign blank    = (sample.an[3:0] == AN_BLANK);
    assign legal    = (sample.an[7:4] == AN_UPPER_IDLE) && an_sel.hit && seg_hit;
    assign capture  = accept && !blank && legal;
    assign cap_bits = capture ? (4'b0001 << an_sel.idx) : 4'b0000;

    // Captures land in the shadows every cycle, including PUBLISH, so the next frame starts without loss
    always_ff @(posedge clk_out_seg or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            mask        <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            BCD0        <= '0;
            BCD1        <= '0;
            BCD2        <= '0;
            BCD3        <= '0;
            DPo         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                shadow_val[an_sel.idx] <= seg_value;
                shadow_dp[an_sel.idx]  <= ~sample.dp;
            end
            case (state)
                COLLECT: begin
                    mask <= mask | cap_bits;
                    if ((mask | cap_bits) == 4'b1111) state <= PUBLISH;
                end
                PUBLISH: begin
                    BCD0        <= shadow_val[0];
                    BCD1        <= shadow_val[1];
                    BCD2        <= shadow_val[2];
                    BCD3        <= shadow_val[3];
                    DPo         <= shadow_dp;
                    frame_valid <= 1'b1;
                    mask        <= cap_bits;
                    state       <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef DECOD7_ERR_EN
    logic reject;
    assign reject = accept && !blank && !legal;

    always_ff @(posedge clk_out_seg or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= reject;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_afisare_7seg_decod.sv
// Directed bench for afisare_7seg_decod: expected frames are queued at stimulus time and
// popped by a monitor whenever frame_valid is seen.
module tb_afisare_7seg_decod;

    localparam int STABLE_N = 2;
`ifdef DECOD7_ERR_EN
    localparam int EXP_ERR = 3;
`else
    localparam int EXP_ERR = 0;
`endif

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dpo;
    } exp_frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] bcd0, bcd1, bcd2, bcd3, dpo;
    logic       frame_valid, err;

    exp_frame_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int frames_seen = 0;
    int err_seen = 0;
    int cycle = 0;
    int fv_cycle = 0;
    int start_cycle = 0;

    afisare_7seg_decod #(.STABLE_N(STABLE_N)) dut (
        .clk_out_seg (clk),
        .reset       (reset),
        .An          (an),
        .Seg         (seg),
        .DP          (dp),
        .BCD0        (bcd0),
        .BCD1        (bcd1),
        .BCD2        (bcd2),
        .BCD3        (bcd3),
        .DPo         (dpo),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h01;   1: return 7'h4F;   2: return 7'h12;   3: return 7'h06;
            4: return 7'h4C;   5: return 7'h24;   6: return 7'h20;   7: return 7'h0F;
            8: return 7'h00;   9: return 7'h04;  10: return 7'h08;  11: return 7'h60;
            12: return 7'h31; 13: return 7'h42;  14: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    function automatic logic [7:0] an_of(input int d);
        case (d)
            0: return 8'hF7;
            1: return 8'hFB;
            2: return 8'hFD;
            default: return 8'hFE;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic apply_raw(input logic [7:0] a, input logic [6:0] s, input logic d, input int hold);
        an  = a;
        seg = s;
        dp  = d;
        repeat (hold) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int digit, input int value, input logic d, input int hold);
        apply_raw(an_of(digit), seg_of(value), d, hold);
    endtask

    task automatic idle(input int n);
        apply_raw(8'hFF, 7'h7F, 1'b1, n);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output("frame_timeout", 16'(frames_seen >= target), 16'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && frame_valid) begin
            frames_seen++;
            fv_cycle = cycle;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_frame: got BCD %h, expected no frame", {bcd3, bcd2, bcd1, bcd0});
            end else begin
                exp_frame_t e;
                e = exp_q.pop_front();
                check_output("frame_bcd", {bcd3, bcd2, bcd1, bcd0}, e.bcd);
                check_output("frame_dpo", 16'(dpo), 16'(e.dpo));
            end
        end
        if (err) err_seen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        an = 8'hFF; seg = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        check_output("reset_dpo", 16'(dpo), 16'h0);
        check_output("reset_fv", 16'(frame_valid), 16'h0);
        check_output("reset_err", 16'(err), 16'h0);
        reset = 1'b1;
        idle(5);

        // Digits 3..0 = 1,2,3,4, digit 2 with its decimal point lit
        exp_q.push_back('{bcd: 16'h1234, dpo: 4'b0100});
        apply_stimulus(3, 1, 1'b1, 4);
        apply_stimulus(2, 2, 1'b0, 4);
        apply_stimulus(1, 3, 1'b1, 4);
        start_cycle = cycle;
        apply_stimulus(0, 4, 1'b1, 4);
        wait_frames(1, 20);
        check_output("latency", 16'(fv_cycle - start_cycle), 16'(STABLE_N + 2));
        idle(8);
        check_output("hold_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h1234);
        check_output("hold_dpo", 16'(dpo), 16'h4);

        // One-cycle illegal glitch between digits is never accepted
        exp_q.push_back('{bcd: 16'h5678, dpo: 4'b0000});
        apply_stimulus(3, 5, 1'b1, 4);
        apply_raw(8'hF0, 7'h55, 1'b1, 1);
        apply_stimulus(2, 6, 1'b1, 4);
        apply_stimulus(1, 7, 1'b1, 4);
        apply_stimulus(0, 8, 1'b1, 4);
        wait_frames(2, 20);
        idle(4);
        check_output("glitch_err", 16'(err_seen), 16'd0);

        // Undecodable samples: bad segments, bad upper anodes, two anodes low
        apply_raw(an_of(0), 7'h55, 1'b1, 4);
        apply_raw(8'h0E, seg_of(1), 1'b1, 4);
        apply_raw(8'hF3, seg_of(1), 1'b1, 4);
        apply_stimulus(3, 9, 1'b1, 4);
        apply_stimulus(2, 10, 1'b1, 4);
        apply_stimulus(1, 11, 1'b1, 4);
        idle(10);
        check_output("bad_no_frame", 16'(frames_seen), 16'd2);
        check_output("bad_hold_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h5678);
        check_output("bad_err_count", 16'(err_seen), 16'(EXP_ERR));
        exp_q.push_back('{bcd: 16'h9ABC, dpo: 4'b0000});
        apply_stimulus(0, 12, 1'b1, 4);
        wait_frames(3, 20);
        idle(4);

        // Reset in the middle of a frame
        apply_stimulus(3, 1, 1'b1, 4);
        apply_stimulus(2, 1, 1'b1, 4);
        apply_stimulus(1, 1, 1'b1, 4);
        idle(2);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_output("midreset_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        check_output("midreset_dpo", 16'(dpo), 16'h0);
        check_output("midreset_fv", 16'(frame_valid), 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
        apply_stimulus(0, 5, 1'b1, 4);
        idle(10);
        check_output("reset_partial_dropped", 16'(frames_seen), 16'd3);
        exp_q.push_back('{bcd: 16'h2345, dpo: 4'b1111});
        apply_stimulus(0, 5, 1'b0, 4);
        apply_stimulus(1, 4, 1'b0, 4);
        apply_stimulus(2, 3, 1'b0, 4);
        apply_stimulus(3, 2, 1'b0, 4);
        wait_frames(4, 20);
        idle(4);

        // Digit 1 re-sent within a frame: newest value wins, single frame
        exp_q.push_back('{bcd: 16'h0172, dpo: 4'b1001});
        apply_stimulus(3, 0, 1'b0, 4);
        apply_stimulus(1, 5, 1'b1, 4);
        apply_stimulus(2, 1, 1'b1, 4);
        apply_stimulus(1, 7, 1'b1, 4);
        apply_stimulus(0, 2, 1'b0, 4);
        wait_frames(5, 20);
        idle(10);
        check_output("recapture_single", 16'(frames_seen), 16'd5);
        check_output("final_err_count", 16'(err_seen), 16'(EXP_ERR));
        check_output("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
